// File: rtl/xpb_accum_seq.sv
// xpb_accum_seq: walks the per-segment xpb reduction tables for one squaring step and sums the multiples.
// Optional build macro XPB_ZERO_SKIP_EN skips segments whose index is zero (their table entry is zero).
//
// state  | meaning
// IDLE   | waiting for start_i; acc_o keeps the last result
// LOOKUP | one segment per cycle: drive sel/idx, add tbl_data_i into the accumulator
// HOLD   | acc_valid_o high, waiting for acc_ready_i
module xpb_accum_seq #(
   parameter int SEG_BITS  = 5,
   parameter int NUM_SEG   = 8,
   parameter int WORD_BITS = 1024,
   parameter int ACC_BITS  = WORD_BITS + $clog2(NUM_SEG)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic                         clear_i,
   input  logic [NUM_SEG*SEG_BITS-1:0]  upper_i,
   output logic                         busy_o,
   output logic [$clog2(NUM_SEG)-1:0]   tbl_sel_o,
   output logic [SEG_BITS-1:0]          tbl_idx_o,
   input  logic [WORD_BITS-1:0]         tbl_data_i,
   output logic                         acc_valid_o,
   input  logic                         acc_ready_i,
   output logic [ACC_BITS-1:0]          acc_o
);

   localparam int CNT_W = $clog2(NUM_SEG);

   typedef enum logic [1:0] {IDLE, LOOKUP, HOLD} state_t;

   state_t               state_q, state_d;
   logic [SEG_BITS-1:0]  seg_q [NUM_SEG];
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ACC_BITS-1:0]  acc_q, acc_d;
   logic                 capture;
   logic                 first_none;
   logic [CNT_W-1:0]     first_cnt;
   logic                 last_seg;
   logic [CNT_W-1:0]     next_cnt;

`ifdef XPB_ZERO_SKIP_EN
   // Descending scans so the lowest qualifying segment wins.
   always_comb begin
      first_none = 1'b1;
      first_cnt  = '0;
      for (int k = NUM_SEG-1; k >= 0; k--) begin
         if (upper_i[k*SEG_BITS +: SEG_BITS] != '0) begin
            first_none = 1'b0;
            first_cnt  = CNT_W'(k);
         end
      end
   end

   always_comb begin
      last_seg = 1'b1;
      next_cnt = '0;
      for (int k = NUM_SEG-1; k >= 0; k--) begin
         if (k > int'(cnt_q) && seg_q[k] != '0) begin
            last_seg = 1'b0;
            next_cnt = CNT_W'(k);
         end
      end
   end
`else
   assign first_none = 1'b0;
   assign first_cnt  = '0;
   assign last_seg   = (cnt_q == CNT_W'(NUM_SEG-1));
   assign next_cnt   = cnt_q + CNT_W'(1);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               capture = 1'b1;
               acc_d   = '0;
               cnt_d   = first_cnt;
               state_d = first_none ? HOLD : LOOKUP;
            end
         end
         LOOKUP: begin
            acc_d = acc_q + {{(ACC_BITS-WORD_BITS){1'b0}}, tbl_data_i};
            if (last_seg) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d   = next_cnt;
            end
         end
         HOLD: begin
            if (acc_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         acc_d   = '0;
         capture = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         for (int k = 0; k < NUM_SEG; k++) seg_q[k] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         if (capture) begin
            for (int k = 0; k < NUM_SEG; k++) seg_q[k] <= upper_i[k*SEG_BITS +: SEG_BITS];
         end
      end
   end

   // Table lines are gated by state so they read zero outside LOOKUP, including right after reset.
   assign busy_o      = (state_q != IDLE);
   assign acc_valid_o = (state_q == HOLD);
   assign acc_o       = acc_q;
   assign tbl_sel_o   = (state_q == LOOKUP) ? cnt_q : '0;
   assign tbl_idx_o   = (state_q == LOOKUP) ? seg_q[cnt_q] : '0;

endmodule

// File: tb/tb_xpb_accum_seq.sv
// tb_xpb_accum_seq: directed checks of xpb_accum_seq against a table stub (entry = sel*32 + idx, zero at idx 0).
// Expectations follow the XPB_ZERO_SKIP_EN build setting when it is defined.
module tb_xpb_accum_seq;

   localparam int SEG_BITS  = 5;
   localparam int NUM_SEG   = 8;
   localparam int WORD_BITS = 1024;
   localparam int ACC_BITS  = WORD_BITS + 3;
`ifdef XPB_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic                 clear;
   logic [39:0]          upper;
   logic                 busy;
   logic [2:0]           tbl_sel;
   logic [4:0]           tbl_idx;
   logic [WORD_BITS-1:0] tbl_data;
   logic                 acc_valid;
   logic                 acc_ready;
   logic [ACC_BITS-1:0]  acc;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   xpb_accum_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .clear_i     (clear),
      .upper_i     (upper),
      .busy_o      (busy),
      .tbl_sel_o   (tbl_sel),
      .tbl_idx_o   (tbl_idx),
      .tbl_data_i  (tbl_data),
      .acc_valid_o (acc_valid),
      .acc_ready_i (acc_ready),
      .acc_o       (acc)
   );

   always #5 clk = ~clk;

   // A real xpb table holds zero at index 0.
   always_comb begin
      tbl_data = '0;
      if (tbl_idx != 5'd0) tbl_data = WORD_BITS'({tbl_sel, 5'b0}) + WORD_BITS'(tbl_idx);
   end

   task automatic chk(input string tag, input logic [ACC_BITS-1:0] act, input logic [ACC_BITS-1:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [39:0] up, input int exp_sum, input int exp_lat,
                         input logic [2:0] fsel, input logic [4:0] fidx, input bit walk);
      int n;
      start = 1'b1;
      upper = up;
      tick();
      start = 1'b0;
      n = 0;
      while (!acc_valid && n < 20) begin
         if (n == 0) begin
            chk("first_sel", ACC_BITS'(tbl_sel), ACC_BITS'(fsel));
            chk("first_idx", ACC_BITS'(tbl_idx), ACC_BITS'(fidx));
         end
         if (walk) begin
            chk("walk_sel", ACC_BITS'(tbl_sel), ACC_BITS'(n[2:0]));
            chk("walk_idx", ACC_BITS'(tbl_idx), ACC_BITS'(up[n*5 +: 5]));
         end
         upper = ~upper;
         tick();
         n++;
      end
      chk("latency", ACC_BITS'(n), ACC_BITS'(exp_lat));
      chk("sum", acc, ACC_BITS'(exp_sum));
      chk("valid", ACC_BITS'(acc_valid), ACC_BITS'(1));
   endtask

   task automatic ack();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [39:0] ones;
      logic [39:0] seg3;
      logic [39:0] ramp;
      ones = '1;
      seg3 = 40'd2 << 15;
      for (int k = 0; k < NUM_SEG; k++) ramp[k*5 +: 5] = 5'(k);

      rst_n = 1'b0; start = 1'b0; clear = 1'b0; upper = '0; acc_ready = 1'b0;
      #12;
      chk("rst_busy", ACC_BITS'(busy), '0);
      chk("rst_valid", ACC_BITS'(acc_valid), '0);
      chk("rst_acc", acc, '0);
      chk("rst_sel", ACC_BITS'(tbl_sel), '0);
      chk("rst_idx", ACC_BITS'(tbl_idx), '0);
      rst_n = 1'b1;
      tick();

      // all indices 31: 32*(0+..+7) + 8*31 = 1144
      run_op(ones, 1144, 8, 3'd0, 5'd31, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin start = 1'b1; upper = '0; end
         tick();
         start = 1'b0;
         chk("hold_valid", ACC_BITS'(acc_valid), ACC_BITS'(1));
         chk("hold_acc", acc, ACC_BITS'(1144));
      end
      acc_ready = 1'b1;
      start = 1'b1;
      tick();
      acc_ready = 1'b0;
      start = 1'b0;
      chk("ack_valid", ACC_BITS'(acc_valid), '0);
      chk("ack_busy", ACC_BITS'(busy), '0);
      chk("idle_acc_kept", acc, ACC_BITS'(1144));
      tick();
      chk("ack_start_dropped", ACC_BITS'(busy), '0);

      run_op('0, 0, SKIP ? 0 : 8, 3'd0, 5'd0, 1'b1);
      ack();

      run_op(seg3, 98, SKIP ? 1 : 8, SKIP ? 3'd3 : 3'd0, SKIP ? 5'd2 : 5'd0, 1'b0);
      ack();

      start = 1'b1; upper = ones;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("clr_sel_before", ACC_BITS'(tbl_sel), ACC_BITS'(3));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_busy", ACC_BITS'(busy), '0);
      chk("clr_valid", ACC_BITS'(acc_valid), '0);
      chk("clr_acc", acc, '0);
      chk("clr_sel", ACC_BITS'(tbl_sel), '0);
      clear = 1'b1; start = 1'b1;
      tick();
      clear = 1'b0; start = 1'b0;
      chk("clr_beats_start", ACC_BITS'(busy), '0);
      run_op(ones, 1144, 8, 3'd0, 5'd31, 1'b0);
      ack();

      start = 1'b1; upper = ones;
      tick();
      start = 1'b0;
      tick(); tick();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", ACC_BITS'(busy), '0);
      chk("arst_valid", ACC_BITS'(acc_valid), '0);
      chk("arst_acc", acc, '0);
      chk("arst_sel", ACC_BITS'(tbl_sel), '0);
      chk("arst_idx", ACC_BITS'(tbl_idx), '0);
      #2 rst_n = 1'b1;
      tick();

      // segment k holds k: sum over k>=1 of 33*k = 924
      run_op(ramp, 924, SKIP ? 7 : 8, SKIP ? 3'd1 : 3'd0, SKIP ? 5'd1 : 5'd0, 1'b0);
      ack();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
